alu_operand_sel: RTL and testbench
==================================

Name: alu_operand_sel

Overview:
- Parametrised, registered N:1 operand selector for the determinant ALU datapath.
- Generalises the 2:1 32-bit operand mux to NUM_IN channels of WIDTH bits, with a valid/ready handshake, a 2-entry skid buffer and a zero-force mode.
- Sits between the operand register file / multiplier outputs and the ALU input stage. Stalls from the ALU propagate back without dropping operands.

Parameters:
- WIDTH, 32, data width of each channel and of the output.
- NUM_IN, 4, number of input channels (>= 2).
- SEL_W, max(1, clog2(NUM_IN)), select width. Derived; not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- sel  input  SEL_W  channel index, sampled with the beat.
- zero_en  input  1  force beat data to 0, sampled with the beat.
- data_in  input  NUM_IN*WIDTH  packed channels; channel k = data_in[k*WIDTH +: WIDTH].
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the output beat.
- data_out  output  WIDTH  selected operand.
- sel_err  output  1  current output beat had an out-of-range select; qualified by out_valid.

Behaviour:
- Only one clock, clk; rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: out_valid=0, data_out=0, sel_err=0, skid entry empty, in_ready=0 while rst=1. in_ready=1 on the first cycle after rst deasserts.
- Input accept: the beat transfers when in_valid && in_ready. Output accept: the beat transfers when out_valid && out_ready.
- Beat value, computed combinationally at accept:
  - zero_en=1 → 0 with sel_err=0.
  - sel < NUM_IN → channel sel with sel_err=0.
  - sel >= NUM_IN → 0 with sel_err=1.
- Latency: 1 cycle. A beat accepted in cycle t appears on data_out with out_valid=1 in cycle t+1 if the output stage is free.
- Storage is a main output register plus one skid register. States:
  - EMPTY: out_valid=0, skid empty.
  - ONE: out_valid=1, skid empty.
  - FULL: out_valid=1, skid holds the next beat.
- in_ready is registered and equals !skid_full. It must not depend combinationally on out_ready.
- Transitions:
  - EMPTY + accept → ONE.
  - ONE + accept + out_ready → ONE; the new beat loads main.
  - ONE + accept + !out_ready → FULL; the new beat loads skid.
  - ONE + !accept + out_ready → EMPTY.
  - FULL + out_ready → ONE; skid moves to main. No accept is possible in FULL because in_ready=0.
- Stability: while out_valid=1 and out_ready=0, data_out and sel_err hold constant.
- Order: beats leave strictly in accept order. No beat is duplicated or dropped.
- Throughput: 1 beat/cycle with out_ready held high.
- in_valid=0 with in_ready=1 changes no state other than draining.
- Reset mid-operation discards both entries. out_valid=0 on the next cycle regardless of out_ready.
- sel and data_in are ignored when no accept occurs, and X on them is permitted then.

Decomposition:
- Shared package alu_pkg holds:
  - default constants ALU_WIDTH=32 and ALU_NUM_OPERANDS=4;
  - a sel_width(n) function returning max(1, clog2(n)).
- Sub-module alu_skid_buf (WIDTH+1 bits: data plus sel_err) holds the 2-entry register/handshake logic.
- The channel select and zero/err logic stays in alu_operand_sel as combinational logic in front of it.

Test Plan:
- Reset, then back-to-back beats with out_ready=1:
  - NUM_IN=4, ch0..3 = 0x11111111, 0x22222222, 0x33333333, 0x44444444.
  - sel = 0, 1, 2, 3 on consecutive cycles → data_out 0x11111111..0x44444444 on cycles t+1..t+4, out_valid continuous, sel_err=0.
- Backpressure: out_ready=0 after the first beat, in_valid held.
  - in_ready drops after the second accept; data_out holds 0x11111111.
  - Release out_ready → 0x22222222 next, no loss or duplication.
- zero_en=1 with sel=2 → data_out=0x00000000, sel_err=0.
- NUM_IN=3, sel=3 → data_out=0, sel_err=1 for exactly that beat; the following sel=1 beat has sel_err=0.
- Reset in FULL state: rst=1 for one cycle → out_valid=0 next cycle, in_ready=0 during reset and 1 after. No stale beat emerges.
- Random in_valid/out_ready (50%), 10k beats, checked against a reference FIFO model → in-order match, in_ready never depends on same-cycle out_ready.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants, helpers and state encoding for the ALU operand path.
package alu_pkg;

  localparam int ALU_WIDTH        = 32;
  localparam int ALU_NUM_OPERANDS = 4;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  // Select width for an n-way mux; a 1:1 or 2:1 still needs one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// Two-entry registered handshake stage: main output register plus one skid
// register, so in_ready never depends combinationally on out_ready.
//
//   state      | meaning
//   -----------+--------------------------------------------
//   SKID_EMPTY | no beat held, out_valid=0
//   SKID_ONE   | beat in main, skid empty, out_valid=1
//   SKID_FULL  | beat in main, next beat in skid, in_ready=0
module alu_skid_buf
  import alu_pkg::*;
#(
  parameter int DW = 33
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  skid_state_e   state_q;
  skid_state_e   state_d;
  logic [DW-1:0] main_q;
  logic [DW-1:0] skid_q;
  logic          accept;
  logic          load_main_in;
  logic          load_main_skid;
  logic          load_skid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SKID_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SKID_EMPTY: if (accept) state_d = SKID_ONE;
      SKID_ONE: begin
        if (accept && !out_ready)      state_d = SKID_FULL;
        else if (!accept && out_ready) state_d = SKID_EMPTY;
      end
      SKID_FULL:  if (out_ready) state_d = SKID_ONE;
      default:    state_d = SKID_EMPTY;
    endcase
  end

  // Readiness comes from registered state only; rst just masks it.
  always_comb begin
    in_ready       = (state_q != SKID_FULL) && !rst;
    out_valid      = (state_q != SKID_EMPTY);
    accept         = in_valid && in_ready;
    load_main_in   = accept && ((state_q == SKID_EMPTY) ||
                                ((state_q == SKID_ONE) && out_ready));
    load_skid      = accept && (state_q == SKID_ONE) && !out_ready;
    load_main_skid = (state_q == SKID_FULL) && out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

  assign out_data = main_q;

endmodule

// File: rtl/alu_operand_sel.sv
// Registered N:1 operand selector with zero-force and out-of-range flag,
// feeding the ALU input stage through a 2-entry skid buffer.
module alu_operand_sel
  import alu_pkg::*;
#(
  parameter  int WIDTH  = ALU_WIDTH,
  parameter  int NUM_IN = ALU_NUM_OPERANDS,
  localparam int SEL_W  = sel_width(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    zero_en,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        data_out,
  output logic                    sel_err
);

  logic [WIDTH-1:0] beat_data;
  logic             beat_err;
  logic [WIDTH:0]   out_beat;

  // An unmatched select yields zero data and raises the error flag.
  always_comb begin
    beat_data = '0;
    beat_err  = 1'b1;
    if (zero_en) begin
      beat_err = 1'b0;
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        if (sel == SEL_W'(k)) begin
          beat_data = data_in[k*WIDTH +: WIDTH];
          beat_err  = 1'b0;
        end
      end
    end
  end

  alu_skid_buf #(
    .DW (WIDTH + 1)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({beat_err, beat_data}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_beat)
  );

  assign data_out = out_beat[WIDTH-1:0];
  assign sel_err  = out_beat[WIDTH];

endmodule

// File: tb/tb_alu_operand_sel.sv
// Scoreboard bench for alu_operand_sel: a 4-channel and a 3-channel instance.
module tb_alu_operand_sel;

  logic         clk = 1'b0;
  logic         rst;

  logic         in_valid4, in_ready4, zero4, out_valid4, out_ready4, err4;
  logic [1:0]   sel4;
  logic [127:0] data4;
  logic [31:0]  dout4;

  logic         in_valid3, in_ready3, zero3, out_valid3, out_ready3, err3;
  logic [1:0]   sel3;
  logic [95:0]  data3;
  logic [31:0]  dout3;

  int n_checks = 0;
  int n_fail   = 0;

  logic [32:0] q4[$];
  logic [32:0] q3[$];

  always #5 clk = ~clk;

  alu_operand_sel #(.WIDTH(32), .NUM_IN(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .sel(sel4), .zero_en(zero4), .data_in(data4), .out_valid(out_valid4),
    .out_ready(out_ready4), .data_out(dout4), .sel_err(err4)
  );

  alu_operand_sel #(.WIDTH(32), .NUM_IN(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
    .sel(sel3), .zero_en(zero3), .data_in(data3), .out_valid(out_valid3),
    .out_ready(out_ready3), .data_out(dout3), .sel_err(err3)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] model4(input logic [1:0] s, input logic z, input logic [127:0] d);
    logic [32:0] r;
    if (z) r = 33'h0;
    else   r = {1'b0, d[s*32 +: 32]};
    return r;
  endfunction

  // Drive one cycle from posedge+1; push the expected beat if it was accepted.
  task automatic beat4(input logic v, input logic [1:0] s, input logic z, input logic ordy,
                       input logic [32:0] exp, input int exp_rdy, output logic acc);
    in_valid4 = v; sel4 = s; zero4 = z; out_ready4 = ordy;
    @(negedge clk);
    if (exp_rdy >= 0) check("in_ready_directed", in_ready4, exp_rdy[0]);
    acc = v && in_ready4;
    if (acc) q4.push_back(exp);
    @(posedge clk); #1;
  endtask

  task automatic beat3(input logic v, input logic [1:0] s, input logic z, input logic [32:0] exp);
    in_valid3 = v; sel3 = s; zero3 = z;
    @(negedge clk);
    if (v && in_ready3) q3.push_back(exp);
    @(posedge clk); #1;
  endtask

  // Monitor for the 4-channel instance: occupancy model, hold check, scoreboard.
  int          occ4 = 0;
  logic        pv = 1'b0, pr = 1'b0, prst = 1'b1;
  logic [32:0] pbeat = '0;
  always @(negedge clk) begin
    if (rst) begin
      q4.delete();
      occ4 = 0;
      prst = 1'b1;
    end else begin
      check("in_ready4", in_ready4, occ4 < 2);
      check("out_valid4", out_valid4, occ4 > 0);
      if (!prst && pv && !pr) begin
        check("hold_valid4", out_valid4, 1'b1);
        check("hold_beat4", {err4, dout4}, pbeat);
      end
      if (out_valid4 && out_ready4) begin
        if (q4.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_beat4: got %h expected none at %0t", {err4, dout4}, $time);
        end else begin
          check("beat4", {err4, dout4}, q4.pop_front());
        end
      end
      occ4 = occ4 + int'(in_valid4 && in_ready4) - int'(out_valid4 && out_ready4);
      pv = out_valid4; pr = out_ready4; pbeat = {err4, dout4}; prst = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q3.delete();
    end else if (out_valid3 && out_ready3) begin
      if (q3.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_beat3: got %h expected none at %0t", {err3, dout3}, $time);
      end else begin
        check("beat3", {err3, dout3}, q3.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic acc;
    int   n_acc;
    int   cyc;
    rst = 1'b1;
    in_valid4 = 0; sel4 = 0; zero4 = 0; out_ready4 = 0;
    in_valid3 = 0; sel3 = 0; zero3 = 0; out_ready3 = 1;
    data4 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    data3 = {32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_in_ready", in_ready4, 1'b0);
    check("rst_out_valid", out_valid4, 1'b0);
    check("rst_data_out", dout4, 32'h0);
    check("rst_sel_err", err4, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", in_ready4, 1'b1);
    @(posedge clk); #1;

    // Back-to-back, out_ready high
    beat4(1, 2'd0, 0, 1, {1'b0, 32'h11111111}, 1, acc);
    beat4(1, 2'd1, 0, 1, {1'b0, 32'h22222222}, 1, acc);
    beat4(1, 2'd2, 0, 1, {1'b0, 32'h33333333}, 1, acc);
    beat4(1, 2'd3, 0, 1, {1'b0, 32'h44444444}, 1, acc);
    beat4(0, 2'd0, 0, 1, 33'h0, 1, acc);
    beat4(0, 2'd0, 0, 1, 33'h0, 1, acc);

    // Backpressure with in_valid held
    beat4(1, 2'd0, 0, 0, {1'b0, 32'h11111111}, 1, acc);
    beat4(1, 2'd1, 0, 0, {1'b0, 32'h22222222}, 1, acc);
    beat4(1, 2'd2, 0, 0, {1'b0, 32'h33333333}, 0, acc);
    check("bp_hold_data", dout4, 32'h11111111);
    beat4(1, 2'd2, 0, 0, {1'b0, 32'h33333333}, 0, acc);
    beat4(1, 2'd2, 0, 1, {1'b0, 32'h33333333}, 0, acc);
    check("bp_release_data", dout4, 32'h22222222);
    beat4(1, 2'd2, 0, 1, {1'b0, 32'h33333333}, 1, acc);
    beat4(0, 2'd0, 0, 1, 33'h0, 1, acc);

    // Zero force
    beat4(1, 2'd2, 1, 1, 33'h0, 1, acc);
    beat4(0, 2'd0, 0, 1, 33'h0, 1, acc);

    // Out-of-range select on the 3-channel instance
    beat3(1, 2'd3, 0, {1'b1, 32'h0});
    beat3(1, 2'd1, 0, {1'b0, 32'hBBBBBBBB});
    beat3(1, 2'd2, 0, {1'b0, 32'hCCCCCCCC});
    beat3(1, 2'd0, 1, {1'b0, 32'h0});
    beat3(0, 2'd0, 0, 33'h0);
    beat3(0, 2'd0, 0, 33'h0);

    // Reset while FULL
    beat4(1, 2'd0, 0, 0, {1'b0, 32'h11111111}, 1, acc);
    beat4(1, 2'd1, 0, 0, {1'b0, 32'h22222222}, 1, acc);
    in_valid4 = 0; out_ready4 = 1; rst = 1'b1;
    @(negedge clk);
    check("rst_full_in_ready", in_ready4, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_out_valid", out_valid4, 1'b0);
    check("post_rst_in_ready", in_ready4, 1'b1);
    @(posedge clk); #1;
    repeat (3) beat4(0, 2'd0, 0, 1, 33'h0, 1, acc);

    // Random traffic against the scoreboard
    n_acc = 0;
    cyc   = 0;
    while (n_acc < 10000 && cyc < 40000) begin
      data4 = {$urandom(), $urandom(), $urandom(), $urandom()};
      sel4  = 2'($urandom_range(0, 3));
      zero4 = ($urandom_range(0, 7) == 0);
      beat4(($urandom_range(0, 1) == 1), sel4, zero4, ($urandom_range(0, 1) == 1),
            model4(sel4, zero4, data4), -1, acc);
      if (acc) n_acc++;
      cyc++;
    end
    check("random_beats", n_acc, 10000);

    for (int i = 0; i < 10 && q4.size() != 0; i++) begin
      beat4(0, 2'd0, 0, 1, 33'h0, -1, acc);
    end
    check("drain4_empty", q4.size(), 0);
    check("drain3_empty", q3.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
